ps2_rx_fifo: RTL and testbench

Parametrised PS/2 device-to-host receiver with input filtering, frame checking, inter-bit timeout and a show-ahead receive FIFO. It sits between the PS/2 connector pins and the scan-code decoder. It runs continuously rather than per-request. Good bytes are queued, bad frames are dropped and flagged, and the PS/2 clock line is held low (inhibit) when the host is disabled or the FIFO is full.

---
 rtl/ps2_rx_fifo_if.sv | 21 ++
 rtl/ps2_rx_fifo.sv | 165 ++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_rx_fifo_if.sv
// ps2_rx_fifo_if: host-side bus of the PS/2 receiver (enable, FIFO read port, status pulses).
interface ps2_rx_fifo_if #(parameter int CW = 4);
   logic          enable;
   logic          rd_ready;
   logic [7:0]    rd_data;
   logic          rd_valid;
   logic [CW-1:0] count;
   logic          busy;
   logic          err_parity;
   logic          err_frame;
   logic          err_timeout;
   logic          overflow;
   modport master (
      output enable, rd_ready,
      input  rd_data, rd_valid, count, busy, err_parity, err_frame, err_timeout, overflow
   );
   modport slave (
      input  enable, rd_ready,
      output rd_data, rd_valid, count, busy, err_parity, err_frame, err_timeout, overflow
   );
endinterface

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 device-to-host receiver with glitch filter, frame checks, timeout and show-ahead FIFO.
module ps2_rx_fifo #(
   parameter int FIFO_DEPTH      = 8,
   parameter int FILTER_LEN      = 4,
   parameter int TIMEOUT         = 2000,
   parameter int INHIBIT_ON_FULL = 1
) (
   input  logic         clock_quarter,
   input  logic         reset,
   ps2_rx_fifo_if.slave bus,
   inout  wire          PS2_CLK,
   input  logic         PS2_DAT
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int GW = $clog2(FILTER_LEN + 4);
   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
   logic [1:0]    pins;
   logic [1:0]    sync_q [2];
   logic [1:0]    filt_q;
   logic [FW-1:0] fcnt_q [2];
   logic          clk_prev_q, fall, din;
   state_t        state_q, state_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          par_q, par_d;
   logic [TW-1:0] to_q, to_d;
   logic          perr_d, ferr_d, terr_d, push;
   logic          perr_q, ferr_q, terr_q, ovf_q;
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wp_q, rp_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          pop, full, wr, inh, drive_q;
   logic [GW-1:0] guard_q;

   assign pins = {PS2_DAT, PS2_CLK};

   always_ff @(posedge clock_quarter) begin
      if (reset) begin
         sync_q     <= '{default: 2'b11};
         filt_q     <= 2'b11;
         fcnt_q     <= '{default: '0};
         clk_prev_q <= 1'b1;
      end else begin
         clk_prev_q <= filt_q[0];
         for (int i = 0; i < 2; i++) begin
            sync_q[i] <= {sync_q[i][0], pins[i]};
            if (sync_q[i][1] == filt_q[i]) fcnt_q[i] <= '0;
            else if (fcnt_q[i] == FW'(FILTER_LEN - 1)) begin
               filt_q[i] <= sync_q[i][1];
               fcnt_q[i] <= '0;
            end else fcnt_q[i] <= fcnt_q[i] + FW'(1);
         end
      end
   end

   // Our own inhibit pulls the line low; mask that edge until the filter has settled again.
   assign fall = clk_prev_q && !filt_q[0] && !drive_q && guard_q == '0;
   assign din  = filt_q[1];

   always_comb begin
      state_d = state_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      par_d   = par_q;
      to_d    = '0;
      perr_d  = 1'b0;
      ferr_d  = 1'b0;
      terr_d  = 1'b0;
      push    = 1'b0;
      if (state_q != IDLE) to_d = fall ? '0 : to_q + TW'(1);
      case (state_q)
         IDLE: if (fall) begin
            if (!din) begin
               state_d = DATA;
               bit_d   = '0;
               shift_d = '0;
            end else ferr_d = 1'b1;
         end
         DATA: if (fall) begin
            shift_d = {din, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = PARITY;
         end
         PARITY: if (fall) begin
            par_d   = din;
            state_d = STOP;
         end
         STOP: if (fall) begin
            state_d = IDLE;
            ferr_d  = !din;
            perr_d  = din && !(^shift_q ^ par_q);
            push    = din && (^shift_q ^ par_q);
         end
         default: state_d = IDLE;
      endcase
      if (state_q != IDLE && !fall && to_q == TW'(TIMEOUT - 1)) begin
         state_d = IDLE;
         terr_d  = 1'b1;
         to_d    = '0;
      end
   end

   always_ff @(posedge clock_quarter) begin
      if (reset) begin
         state_q <= IDLE;
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         to_q    <= '0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
         terr_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         to_q    <= to_d;
         perr_q  <= perr_d;
         ferr_q  <= ferr_d;
         terr_q  <= terr_d;
         ovf_q   <= push && full && !pop;
      end
   end

   assign pop   = bus.rd_valid && bus.rd_ready;
   assign full  = cnt_q == CW'(FIFO_DEPTH);
   assign wr    = push && (!full || pop);
   assign cnt_d = cnt_q + CW'(wr) - CW'(pop);
   assign inh   = !bus.enable || (INHIBIT_ON_FULL != 0 && cnt_d == CW'(FIFO_DEPTH));

   always_ff @(posedge clock_quarter) begin
      if (wr) mem[wp_q] <= shift_q;
   end

   always_ff @(posedge clock_quarter) begin
      if (reset) begin
         wp_q    <= '0;
         rp_q    <= '0;
         cnt_q   <= '0;
         drive_q <= 1'b0;
         guard_q <= '0;
      end else begin
         if (wr) wp_q <= wp_q + AW'(1);
         if (pop) rp_q <= rp_q + AW'(1);
         cnt_q   <= cnt_d;
         drive_q <= inh && state_d == IDLE;
         guard_q <= drive_q ? GW'(FILTER_LEN + 3) : (guard_q != '0 ? guard_q - GW'(1) : '0);
      end
   end

   assign PS2_CLK         = drive_q ? 1'b0 : 1'bz;
   assign bus.rd_valid    = cnt_q != '0;
   assign bus.rd_data     = bus.rd_valid ? mem[rp_q] : 8'h00;
   assign bus.count       = cnt_q;
   assign bus.busy        = state_q != IDLE;
   assign bus.err_parity  = perr_q;
   assign bus.err_frame   = ferr_q;
   assign bus.err_timeout = terr_q;
   assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo: directed PS/2 frames into two receivers (inhibit-on-full and not), checked against hand values.
module tb_ps2_rx_fifo;
   localparam int TO = 300;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;
   logic dclk [2];
   logic ddat [2];
   wire  pclk_a, pclk_b;
   assign pclk_a = dclk[0] ? 1'bz : 1'b0;
   assign pclk_b = dclk[1] ? 1'bz : 1'b0;
   pullup (pclk_a);
   pullup (pclk_b);

   ps2_rx_fifo_if #(.CW(3)) ia ();
   ps2_rx_fifo_if #(.CW(3)) ib ();

   ps2_rx_fifo #(.FIFO_DEPTH(4), .FILTER_LEN(4), .TIMEOUT(TO), .INHIBIT_ON_FULL(1)) u_a (
      .clock_quarter(clk), .reset(rst), .bus(ia.slave), .PS2_CLK(pclk_a), .PS2_DAT(ddat[0]));
   ps2_rx_fifo #(.FIFO_DEPTH(4), .FILTER_LEN(4), .TIMEOUT(TO), .INHIBIT_ON_FULL(0)) u_b (
      .clock_quarter(clk), .reset(rst), .bus(ib.slave), .PS2_CLK(pclk_b), .PS2_DAT(ddat[1]));

   int n_tests = 0, n_fail = 0;
   int np [2], nf [2], nt [2], no [2];

   always @(posedge clk) begin
      if (ia.err_parity) np[0]++;
      if (ia.err_frame) nf[0]++;
      if (ia.err_timeout) nt[0]++;
      if (ia.overflow) no[0]++;
      if (ib.err_parity) np[1]++;
      if (ib.err_frame) nf[1]++;
      if (ib.err_timeout) nt[1]++;
      if (ib.overflow) no[1]++;
   end

   typedef struct {
      logic [7:0] d;
      logic       par;
      logic       stop;
      logic       exp_push;
      logic       exp_perr;
      logic       exp_ferr;
   } vec_t;
   vec_t tv [8];

   function automatic int cnt_of(input int s);
      return s != 0 ? int'(ib.count) : int'(ia.count);
   endfunction
   function automatic int data_of(input int s);
      return s != 0 ? int'(ib.rd_data) : int'(ia.rd_data);
   endfunction
   function automatic int valid_of(input int s);
      return s != 0 ? int'(ib.rd_valid) : int'(ia.rd_valid);
   endfunction
   function automatic int busy_of(input int s);
      return s != 0 ? int'(ib.busy) : int'(ia.busy);
   endfunction
   function automatic int pin_of(input int s);
      return s != 0 ? int'(pclk_b) : int'(pclk_a);
   endfunction
   function automatic logic odd_par(input logic [7:0] d);
      return ~^d;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic set_ready(input int s, input logic v);
      if (s != 0) ib.rd_ready = v;
      else ia.rd_ready = v;
   endtask

   task automatic pop(input int s);
      @(negedge clk);
      set_ready(s, 1'b1);
      @(negedge clk);
      set_ready(s, 1'b0);
   endtask

   // 80-cycle bit period; optional glitches on bits 3/5, optional one-cycle pop aligned to the stop fall
   task automatic send_bits(input int s, input logic [10:0] b, input int n, input bit glitch, input bit pop_stop);
      for (int i = 0; i < n; i++) begin
         ddat[s] = b[i];
         if (glitch && i == 5) begin
            repeat (10) @(negedge clk);
            dclk[s] = 1'b0;
            @(negedge clk);
            dclk[s] = 1'b1;
            repeat (9) @(negedge clk);
         end else repeat (20) @(negedge clk);
         dclk[s] = 1'b0;
         if (pop_stop && i == 10) begin
            repeat (6) @(negedge clk);
            set_ready(s, 1'b1);
            @(negedge clk);
            set_ready(s, 1'b0);
            repeat (33) @(negedge clk);
         end else if (glitch && i == 3) begin
            repeat (15) @(negedge clk);
            dclk[s] = 1'b1;
            @(negedge clk);
            dclk[s] = 1'b0;
            repeat (24) @(negedge clk);
         end else repeat (40) @(negedge clk);
         dclk[s] = 1'b1;
         repeat (20) @(negedge clk);
      end
   endtask

   task automatic frame(input int s, input logic [7:0] d, input logic par, input logic stop,
                        input bit glitch, input bit pop_stop);
      send_bits(s, {stop, par, d, 1'b0}, 11, glitch, pop_stop);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int p0, f0, t0, o0;
      logic [7:0] exp_b [4];
      tv[0] = '{8'h1C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      tv[1] = '{8'hF0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      tv[2] = '{8'hF0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      tv[3] = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      tv[4] = '{8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      tv[5] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      tv[6] = '{8'h80, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      tv[7] = '{8'h80, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      for (int s = 0; s < 2; s++) begin
         dclk[s] = 1'b1;
         ddat[s] = 1'b1;
      end
      ia.enable = 1'b1;
      ib.enable = 1'b1;
      ia.rd_ready = 1'b0;
      ib.rd_ready = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         chk("reset_count", cnt_of(s), 0);
         chk("reset_valid", valid_of(s), 0);
         chk("reset_data", data_of(s), 0);
         chk("reset_busy", busy_of(s), 0);
         chk("reset_pin", pin_of(s), 1);
      end
      rst = 1'b0;
      repeat (10) @(negedge clk);

      for (int k = 0; k < 8; k++) begin
         p0 = np[0];
         f0 = nf[0];
         frame(0, tv[k].d, tv[k].par, tv[k].stop, 1'b0, 1'b0);
         chk("vec_count", cnt_of(0), int'(tv[k].exp_push));
         chk("vec_perr", np[0] - p0, int'(tv[k].exp_perr));
         chk("vec_ferr", nf[0] - f0, int'(tv[k].exp_ferr));
         if (tv[k].exp_push) begin
            chk("vec_data", data_of(0), int'(tv[k].d));
            pop(0);
            chk("vec_pop_count", cnt_of(0), 0);
         end else chk("vec_valid", valid_of(0), 0);
      end

      f0 = nf[0];
      send_bits(0, 11'h7FF, 1, 1'b0, 1'b0);
      chk("bad_start_ferr", nf[0] - f0, 1);
      chk("bad_start_busy", busy_of(0), 0);

      t0 = nt[0];
      send_bits(0, 11'h7FE, 5, 1'b0, 1'b0);
      chk("partial_busy", busy_of(0), 1);
      repeat (TO + 10) @(negedge clk);
      chk("timeout_pulse", nt[0] - t0, 1);
      chk("timeout_busy", busy_of(0), 0);
      chk("timeout_count", cnt_of(0), 0);
      frame(0, 8'h5A, odd_par(8'h5A), 1'b1, 1'b0, 1'b0);
      chk("after_to_data", data_of(0), 8'h5A);
      chk("after_to_count", cnt_of(0), 1);
      pop(0);

      p0 = np[0];
      f0 = nf[0];
      frame(0, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("glitch_data", data_of(0), 8'hA5);
      chk("glitch_count", cnt_of(0), 1);
      chk("glitch_errs", (np[0] - p0) + (nf[0] - f0), 0);
      pop(0);

      ia.enable = 1'b0;
      repeat (3) @(negedge clk);
      chk("disable_pin", pin_of(0), 0);
      ia.enable = 1'b1;
      repeat (2) @(negedge clk);
      chk("enable_pin", pin_of(0), 1);
      repeat (20) @(negedge clk);

      for (int k = 1; k <= 4; k++) begin
         frame(0, 8'(k), odd_par(8'(k)), 1'b1, 1'b0, 1'b0);
         chk(k == 4 ? "fill_pin_full" : "fill_pin", pin_of(0), k == 4 ? 0 : 1);
      end
      chk("full_count", cnt_of(0), 4);
      chk("full_head", data_of(0), 8'h01);
      pop(0);
      chk("release_pin", pin_of(0), 1);
      chk("release_count", cnt_of(0), 3);
      for (int k = 2; k <= 4; k++) begin
         chk("drain_data", data_of(0), k);
         pop(0);
      end
      chk("drain_empty", valid_of(0), 0);

      for (int k = 0; k < 4; k++) frame(1, 8'h11 + 8'(k), odd_par(8'h11 + 8'(k)), 1'b1, 1'b0, 1'b0);
      chk("b_full_count", cnt_of(1), 4);
      chk("b_no_inhibit", pin_of(1), 1);
      o0 = no[1];
      frame(1, 8'h77, odd_par(8'h77), 1'b1, 1'b0, 1'b0);
      chk("ovf_pulse", no[1] - o0, 1);
      chk("ovf_count", cnt_of(1), 4);
      chk("ovf_head", data_of(1), 8'h11);
      o0 = no[1];
      frame(1, 8'h77, odd_par(8'h77), 1'b1, 1'b0, 1'b1);
      chk("pushpop_ovf", no[1] - o0, 0);
      chk("pushpop_count", cnt_of(1), 4);
      exp_b = '{8'h12, 8'h13, 8'h14, 8'h77};
      for (int k = 0; k < 4; k++) begin
         chk("b_drain_data", data_of(1), int'(exp_b[k]));
         pop(1);
      end
      chk("b_drain_count", cnt_of(1), 0);

      frame(0, 8'h42, odd_par(8'h42), 1'b1, 1'b0, 1'b0);
      chk("pre_reset_count", cnt_of(0), 1);
      send_bits(0, 11'h7F8, 3, 1'b0, 1'b0);
      chk("pre_reset_busy", busy_of(0), 1);
      p0 = np[0];
      f0 = nf[0];
      t0 = nt[0];
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_reset_count", cnt_of(0), 0);
      chk("mid_reset_valid", valid_of(0), 0);
      chk("mid_reset_data", data_of(0), 0);
      chk("mid_reset_busy", busy_of(0), 0);
      chk("mid_reset_pin", pin_of(0), 1);
      rst = 1'b0;
      repeat (TO + 10) @(negedge clk);
      chk("mid_reset_errs", (np[0] - p0) + (nf[0] - f0) + (nt[0] - t0), 0);
      frame(0, 8'h3C, odd_par(8'h3C), 1'b1, 1'b0, 1'b0);
      chk("post_reset_data", data_of(0), 8'h3C);
      chk("post_reset_count", cnt_of(0), 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
